// File: rtl/hex_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// hex_seq_ctrl_if
// Request/response bus between the hex display sequencer (master) and the
// display controller's slave port.
//   req   : access request, one access per cycle
//   addr  : byte address of the peripheral register
//   we    : 1 = write, 0 = read
//   wdata : write data
//   rdata : registered read data, valid the cycle after a granted read
// -----------------------------------------------------------------------------
interface hex_seq_ctrl_if;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output req, output addr, output we, output wdata, input rdata);
  modport slave  (input req, input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/hex_seq_ctrl.sv
// -----------------------------------------------------------------------------
// hex_seq_ctrl
// Loads the eight-digit hex display: on a command it issues eight digit
// writes (BASE_ADDR+4k, nibble k of the value) followed by one bitmask write
// (BASE_ADDR+0x20). CPU accesses share the peripheral port and are arbitrated
// round-robin against the sequencer, one access per cycle.
//   clk_i, rst          : clock, synchronous active-high reset
//   cpu_*               : CPU pass-through (req/addr/we/wdata in, rdata/stall out)
//   cmd_valid_i/ready_o : command handshake carrying cmd_value_i, cmd_mask_i
//   busy_o, done_o      : sequence in progress / one-cycle completion pulse
//   per                 : master side of the peripheral bus
// -----------------------------------------------------------------------------
module hex_seq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic               clk_i,
  input  logic               rst,
  input  logic               cpu_req_i,
  input  logic [31:0]        cpu_addr_i,
  input  logic               cpu_we_i,
  input  logic [31:0]        cpu_wdata_i,
  output logic [31:0]        cpu_rdata_o,
  output logic               cpu_stall_o,
  input  logic               cmd_valid_i,
  input  logic [31:0]        cmd_value_i,
  input  logic [7:0]         cmd_mask_i,
  output logic               cmd_ready_o,
  output logic               busy_o,
  output logic               done_o,
  hex_seq_ctrl_if.master     per
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic PRIO_CPU = 1'b0;
  localparam logic PRIO_SEQ = 1'b1;

  state_e      state_q, state_d;
  logic [3:0]  step_q, step_d;
  logic [31:0] value_q, value_d;
  logic [7:0]  mask_q, mask_d;
  logic        prio_q, prio_d;

  logic        seq_req_s;
  logic [31:0] seq_addr_s;
  logic [31:0] seq_wdata_s;
  logic        cpu_grant_s;
  logic        seq_grant_s;

  // State, step counter, latched command and arbitration priority registers.
  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= 4'd0;
      value_q <= 32'd0;
      mask_q  <= 8'd0;
      prio_q  <= PRIO_CPU;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      value_q <= value_d;
      mask_q  <= mask_d;
      prio_q  <= prio_d;
    end
  end

  // Sequencer next-state logic and the write it currently wants to issue.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    value_d     = value_q;
    mask_d      = mask_q;
    seq_req_s   = 1'b0;
    seq_addr_s  = 32'd0;
    seq_wdata_s = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          value_d = cmd_value_i;
          mask_d  = cmd_mask_i;
          step_d  = 4'd0;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        seq_req_s = 1'b1;
        if (step_q < 4'd8) begin
          seq_addr_s  = BASE_ADDR + {26'd0, step_q, 2'b00};
          seq_wdata_s = {28'd0, value_q[{step_q[2:0], 2'b00} +: 4]};
        end else begin
          seq_addr_s  = BASE_ADDR + 32'h20;
          seq_wdata_s = {24'd0, mask_q};
        end
        // The step only moves when the write actually reached the port.
        if (seq_grant_s) begin
          if (step_q == 4'd8) begin
            state_d = ST_DONE;
          end else begin
            step_d = step_q + 4'd1;
          end
        end else begin
          step_d = step_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Round-robin grant and peripheral bus mux; prio only flips on contested cycles.
  always_comb begin
    cpu_grant_s = 1'b0;
    seq_grant_s = 1'b0;
    prio_d      = prio_q;
    per.req     = cpu_req_i | seq_req_s;
    per.addr    = 32'd0;
    per.we      = 1'b0;
    per.wdata   = 32'd0;
    if (cpu_req_i && seq_req_s) begin
      cpu_grant_s = (prio_q == PRIO_CPU);
      seq_grant_s = (prio_q == PRIO_SEQ);
      prio_d      = ~prio_q;
    end else begin
      cpu_grant_s = cpu_req_i;
      seq_grant_s = seq_req_s;
    end
    if (seq_grant_s) begin
      per.addr  = seq_addr_s;
      per.we    = 1'b1;
      per.wdata = seq_wdata_s;
    end else if (cpu_grant_s) begin
      per.addr  = cpu_addr_i;
      per.we    = cpu_we_i;
      per.wdata = cpu_wdata_i;
    end else begin
      per.addr  = 32'd0;
      per.we    = 1'b0;
      per.wdata = 32'd0;
    end
  end

  assign cpu_rdata_o = per.rdata;
  assign cpu_stall_o = cpu_req_i & ~cpu_grant_s;
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);

endmodule

// File: tb/tb_hex_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hex_seq_ctrl
// Self-checking bench. The reference model keeps a queue of the writes a
// command still owes the display, a done-pending flag and the round-robin
// turn; every cycle it predicts all outputs of two instances (BASE_ADDR 0x0
// and 0x100) driven by the same stimulus.
// -----------------------------------------------------------------------------
module tb_hex_seq_ctrl;

  logic        clk_i = 1'b0;
  logic        rst;
  logic        cpu_req_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_we_i;
  logic [31:0] cpu_wdata_i;
  logic        cmd_valid_i;
  logic [31:0] cmd_value_i;
  logic [7:0]  cmd_mask_i;
  logic [31:0] per_rdata_s;

  logic [31:0] cpu_rdata0_s, cpu_rdata1_s;
  logic        cpu_stall0_s, cpu_stall1_s;
  logic        cmd_ready0_s, cmd_ready1_s;
  logic        busy0_s, busy1_s;
  logic        done0_s, done1_s;

  hex_seq_ctrl_if bus0 ();
  hex_seq_ctrl_if bus1 ();
  assign bus0.rdata = per_rdata_s;
  assign bus1.rdata = per_rdata_s;

  always #5 clk_i = ~clk_i;

  hex_seq_ctrl #(.BASE_ADDR(32'h0)) u_dut (
    .clk_i(clk_i), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata0_s), .cpu_stall_o(cpu_stall0_s),
    .cmd_valid_i(cmd_valid_i), .cmd_value_i(cmd_value_i), .cmd_mask_i(cmd_mask_i),
    .cmd_ready_o(cmd_ready0_s), .busy_o(busy0_s), .done_o(done0_s),
    .per(bus0.master)
  );

  hex_seq_ctrl #(.BASE_ADDR(32'h100)) u_dut_b100 (
    .clk_i(clk_i), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_addr_i(cpu_addr_i), .cpu_we_i(cpu_we_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata1_s), .cpu_stall_o(cpu_stall1_s),
    .cmd_valid_i(cmd_valid_i), .cmd_value_i(cmd_value_i), .cmd_mask_i(cmd_mask_i),
    .cmd_ready_o(cmd_ready1_s), .busy_o(busy1_s), .done_o(done1_s),
    .per(bus1.master)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] off;
    logic [31:0] data;
  } wr_t;

  wr_t m_q[$];
  bit  m_done;
  bit  m_prio;   // 0: CPU wins the next contested cycle, 1: sequencer does

  int err_cnt = 0;
  int chk_cnt = 0;
  bit last_done;
  bit last_accept;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: predict and compare at the falling edge, advance the
  // model at the rising edge, then leave the caller #1 to drive new inputs.
  task automatic tick();
    bit seq, idle, seq_win, cpu_win, cont;
    logic [31:0] ea0, ea1, ewd;
    logic ewe;
    per_rdata_s = $urandom;
    @(negedge clk_i);
    seq     = (m_q.size() != 0);
    idle    = !seq && !m_done;
    cont    = cpu_req_i && seq;
    seq_win = seq && (!cpu_req_i || m_prio);
    cpu_win = cpu_req_i && !seq_win;
    ea0 = 32'd0; ea1 = 32'd0; ewe = 1'b0; ewd = 32'd0;
    if (seq_win) begin
      ea0 = m_q[0].off; ea1 = 32'h100 + m_q[0].off; ewe = 1'b1; ewd = m_q[0].data;
    end else if (cpu_win) begin
      ea0 = cpu_addr_i; ea1 = cpu_addr_i; ewe = cpu_we_i; ewd = cpu_wdata_i;
    end
    check_eq("cmd_ready", {31'd0, cmd_ready0_s}, {31'd0, idle});
    check_eq("busy",      {31'd0, busy0_s},      {31'd0, !idle});
    check_eq("done",      {31'd0, done0_s},      {31'd0, m_done});
    check_eq("stall",     {31'd0, cpu_stall0_s}, {31'd0, cpu_req_i && !cpu_win});
    check_eq("per_req",   {31'd0, bus0.req},     {31'd0, cpu_req_i || seq});
    check_eq("per_addr",  bus0.addr,  ea0);
    check_eq("per_we",    {31'd0, bus0.we},      {31'd0, ewe});
    check_eq("per_wdata", bus0.wdata, ewd);
    check_eq("cpu_rdata", cpu_rdata0_s, per_rdata_s);
    check_eq("b100_addr", bus1.addr,  ea1);
    check_eq("b100_wdata", bus1.wdata, ewd);
    check_eq("b100_done", {31'd0, done1_s},      {31'd0, m_done});
    check_eq("b100_stall", {31'd0, cpu_stall1_s}, {31'd0, cpu_req_i && !cpu_win});
    last_done   = done0_s;
    last_accept = cmd_ready0_s && cmd_valid_i;
    @(posedge clk_i);
    if (rst) begin
      m_q.delete();
      m_done = 1'b0;
      m_prio = 1'b0;
    end else begin
      m_done = 1'b0;
      if (cont) m_prio = !m_prio;
      if (seq_win) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_done = 1'b1;
      end
      if (idle && cmd_valid_i) begin
        for (int k = 0; k < 8; k++) begin
          m_q.push_back('{off: 32'(4 * k), data: (cmd_value_i >> (4 * k)) & 32'hF});
        end
        m_q.push_back('{off: 32'h20, data: {24'd0, cmd_mask_i}});
      end
    end
    #1;
  endtask

  task automatic cpu_idle();
    cpu_req_i = 1'b0; cpu_addr_i = 32'd0; cpu_we_i = 1'b0; cpu_wdata_i = 32'd0;
  endtask

  // Offer a command for one cycle (cycle 0), then count cycles until done_o.
  task automatic run_cmd(input logic [31:0] val, input logic [7:0] msk, output int lat);
    cmd_valid_i = 1'b1; cmd_value_i = val; cmd_mask_i = msk;
    tick();
    cmd_valid_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (last_done && lat < 0) lat = n;
    end
  endtask

  initial begin
    int lat;
    int acc_cyc;
    bit seen_done;
    rst = 1'b1; cmd_valid_i = 1'b0; cmd_value_i = 32'd0; cmd_mask_i = 8'd0;
    per_rdata_s = 32'd0;
    cpu_idle();
    m_done = 1'b0; m_prio = 1'b0;
    @(posedge clk_i); @(posedge clk_i); #1;

    // Reset state, with a CPU write passing through during reset.
    cpu_req_i = 1'b1; cpu_addr_i = 32'h24; cpu_we_i = 1'b1; cpu_wdata_i = 32'h1;
    tick();
    rst = 1'b0;
    cpu_idle();
    tick();

    // Uncontested sequence: nine writes in cycles 1..9, done_o in cycle 10.
    run_cmd(32'h1234ABCD, 8'hF0, lat);
    check_eq("lat_uncontested", lat, 32'd10);

    // CPU read with idle sequencer.
    cpu_req_i = 1'b1; cpu_addr_i = 32'h04; cpu_we_i = 1'b0;
    tick();
    cpu_idle();
    tick();

    // Continuous CPU writes to 0x00: 18 WRITE cycles, done_o in cycle 19.
    cpu_req_i = 1'b1; cpu_addr_i = 32'h00; cpu_we_i = 1'b1; cpu_wdata_i = 32'h5;
    run_cmd(32'h89ABCDEF, 8'h3C, lat);
    check_eq("lat_contended", lat, 32'd19);
    cpu_idle();
    tick();

    // Command held from cycle 3 while busy: accepted at the end of cycle 11.
    cmd_valid_i = 1'b1; cmd_value_i = 32'hCAFE0001; cmd_mask_i = 8'h81;
    tick();
    cmd_value_i = 32'h0F1E2D3C; cmd_mask_i = 8'h5A;
    cmd_valid_i = 1'b0;
    acc_cyc = -1;
    for (int n = 1; n <= 30; n++) begin
      cmd_valid_i = (n >= 3) && (acc_cyc < 0);
      tick();
      if (last_accept && acc_cyc < 0) acc_cyc = n;
    end
    cmd_valid_i = 1'b0;
    check_eq("busy_accept_cycle", acc_cyc, 32'd11);

    // Reset while step 4 is on the bus: no done pulse afterwards.
    cmd_valid_i = 1'b1; cmd_value_i = 32'h76543210; cmd_mask_i = 8'hFF;
    tick();
    cmd_valid_i = 1'b0;
    for (int n = 1; n <= 4; n++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 15; n++) begin
      tick();
      if (last_done) seen_done = 1'b1;
    end
    check_eq("rst_no_done", {31'd0, seen_done}, 32'd0);

    // Randomized traffic, commands and occasional resets.
    for (int n = 0; n < 600; n++) begin
      cpu_req_i   = 1'($urandom_range(0, 1));
      cpu_addr_i  = $urandom;
      cpu_we_i    = 1'($urandom_range(0, 1));
      cpu_wdata_i = $urandom;
      cmd_valid_i = ($urandom_range(0, 3) == 0);
      cmd_value_i = $urandom;
      cmd_mask_i  = 8'($urandom);
      rst         = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0; cmd_valid_i = 1'b0; cpu_idle();
    for (int n = 0; n < 25; n++) tick();

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
